// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_pkg
//  Brief    : Shared types and constants for the button controller: debounce
//             FSM state encoding, channel index map and default parameters.
//  Revision : 1.0 - initial release
// ============================================================================
package control_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } deb_state_t;

    // Channel index map of the front panel
    localparam int CH_AUMF  = 0;
    localparam int CH_BAJAF = 1;
    localparam int CH_AUMC  = 2;
    localparam int CH_BAJAC = 3;
    localparam int CH_MODO  = 4;
    localparam int CH_MRST  = 5;

    // Default parameter values
    localparam int N_CH_DEF    = 6;
    localparam int N_PAIR_DEF  = 2;
    localparam int DEB_CYC_DEF = 50000;
    localparam int CNT_W_DEF   = 16;
    localparam int REP_DLY_DEF = 25000000;
    localparam int REP_PER_DEF = 5000000;

    // Opposite channel of an up/down pair (2k <-> 2k+1)
    function automatic int partner_of(input int ch);
        return ch ^ 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/boton_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : boton_debounce
//  Brief    : One button channel: 2-flop synchroniser, IDLE/DEB_PRESS/HELD/
//             DEB_REL debounce FSM with saturating counter, registered press
//             event. Auto-repeat is built only when
//             CONTROL_BOTONES_AUTOREPEAT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module boton_debounce
    import control_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
`ifdef CONTROL_BOTONES_AUTOREPEAT_EN
    ,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
`endif
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic event_o,
    output logic held_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       sync_q;
    logic             s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             event_q, event_d;

    // Two-flop synchroniser for the raw asynchronous button level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], btn_i};
    end

    assign s       = sync_q[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef CONTROL_BOTONES_AUTOREPEAT_EN
    // Repeat counter is sized from the delays themselves, not CNT_W, so the
    // large default repeat timings still fit.
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REP_DLY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REP_PER - 1);
    localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);

    logic [REP_W-1:0] rcnt_q, rcnt_d;
    logic             rfirst_q, rfirst_d;

    // Repeat timer state: counts cycles spent continuously in HELD
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end
`endif

    // Next-state logic: debounce transitions, counter clear on every change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        event_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    event_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef CONTROL_BOTONES_AUTOREPEAT_EN
        // Any cycle not spent staying in HELD restarts the initial delay
        rcnt_d   = '0;
        rfirst_d = 1'b1;
        if (state_q == HELD && state_d == HELD) begin
            if (rcnt_q >= (rfirst_q ? REP_DLY_LAST : REP_PER_LAST)) begin
                event_d  = 1'b1;
                rcnt_d   = '0;
                rfirst_d = 1'b0;
            end else begin
                rcnt_d   = rcnt_q + REP_ONE;
                rfirst_d = rfirst_q;
            end
        end
`endif
    end

    // FSM state, debounce counter and event register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end

    assign event_o = event_q;
    assign held_o  = (state_q == HELD);
    assign level_o = (state_q == HELD) || (state_q == DEB_REL);

endmodule
`default_nettype wire

// File: rtl/control_botones.sv
`default_nettype none
// ============================================================================
//  Module   : control_botones
//  Brief    : Front-panel button controller. N_CH debounced channels with
//             up/down pair arbitration and master inhibit (MEn). Optional
//             auto-repeat enabled by macro CONTROL_BOTONES_AUTOREPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module control_botones
    import control_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int N_PAIR  = N_PAIR_DEF,
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N_CH-1:0] btn_i,
    input  logic            MEn,
    output logic [N_CH-1:0] pulse_o,
    output logic [N_CH-1:0] level_o
);

    logic [N_CH-1:0] ev, held, lvl, supp;
    logic [N_CH-1:0] pulse_d, pulse_q, level_d, level_q;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            boton_debounce #(
                .DEB_CYC (DEB_CYC),
                .CNT_W   (CNT_W)
`ifdef CONTROL_BOTONES_AUTOREPEAT_EN
                ,
                .REP_DLY (REP_DLY),
                .REP_PER (REP_PER)
`endif
            ) u_deb (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .btn_i   (btn_i[i]),
                .event_o (ev[i]),
                .held_o  (held[i]),
                .level_o (lvl[i])
            );

            // A paired channel loses its event while the partner is HELD; a
            // simultaneous press leaves both HELD, so both are dropped.
            if (i < 2 * N_PAIR) begin : g_pair
                assign supp[i] = held[partner_of(i)];
            end else begin : g_solo
                assign supp[i] = 1'b0;
            end
        end
    endgenerate

    // Inhibit and arbitration: inhibited events are dropped, never queued
    always_comb begin
        pulse_d = MEn ? '0 : (ev & ~supp);
        level_d = MEn ? '0 : lvl;
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pulse_q <= '0;
            level_q <= '0;
        end else begin
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule
`default_nettype wire

// File: tb/tb_control_botones.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_botones
//  Brief    : Self-checking bench for control_botones with a behavioural
//             reference model (sliding-window debounce, pair/inhibit rules).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_botones;

    localparam int N_CH    = 6;
    localparam int N_PAIR  = 2;
    localparam int DEB_CYC = 4;
    localparam int CNT_W   = 16;
    localparam int REP_DLY = 20;
    localparam int REP_PER = 8;
    localparam int LAT     = DEB_CYC + 3;
    localparam logic [15:0] WMASK = 16'((1 << (DEB_CYC + 1)) - 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn;
    logic            men;
    wire  [N_CH-1:0] pulse;
    wire  [N_CH-1:0] level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    control_botones #(
        .N_CH(N_CH), .N_PAIR(N_PAIR), .DEB_CYC(DEB_CYC),
        .CNT_W(CNT_W), .REP_DLY(REP_DLY), .REP_PER(REP_PER)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .btn_i   (btn),
        .MEn     (men),
        .pulse_o (pulse),
        .level_o (level)
    );

    // Reference model: a debounced level flips once the raw samples seen two
    // edges ago and the DEB_CYC before them all disagree with it.
    logic [15:0]     m_hist [N_CH];
    logic [N_CH-1:0] m_L, m_held, m_ev, m_supp, m_pulse, m_level;
    int              m_hr [N_CH];

    task automatic model_clear();
        for (int i = 0; i < N_CH; i++) begin
            m_hist[i] = '0;
            m_hr[i]   = 0;
        end
        m_L = '0; m_held = '0; m_ev = '0; m_supp = '0;
        m_pulse = '0; m_level = '0;
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] nheld;
        logic [15:0]     win;
        logic            nl, rise, rep;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            m_pulse[i] = m_ev[i] & ~m_supp[i] & ~men;
            m_level[i] = m_L[i] & ~men;
        end
        nheld = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_hist[i] = {m_hist[i][14:0], btn[i]};
            win  = (m_hist[i] >> 2) & WMASK;
            nl   = m_L[i] ? (win != 16'd0) : (win == WMASK);
            rise = !m_L[i] && nl;
            nheld[i] = nl && m_hist[i][2];
            if (nheld[i] && m_held[i]) m_hr[i] = m_hr[i] + 1;
            else                       m_hr[i] = 0;
            rep = 1'b0;
`ifdef CONTROL_BOTONES_AUTOREPEAT_EN
            rep = nheld[i] && m_held[i] &&
                  (m_hr[i] == REP_DLY ||
                   (m_hr[i] > REP_DLY && ((m_hr[i] - REP_DLY) % REP_PER) == 0));
`endif
            m_ev[i] = rise | rep;
            m_L[i]  = nl;
        end
        m_held = nheld;
        for (int i = 0; i < N_CH; i++)
            m_supp[i] = (i < 2 * N_PAIR) ? m_held[i ^ 1] : 1'b0;
    endtask

    // One clock: model follows the active edge, outputs settle by the negedge
    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int rel_edge, pedge;
        rst_n = 1'b0; btn = '0; men = 1'b0;
        model_clear();
        repeat (3) tick();
        checks++;
        if (pulse !== '0) begin errors++; $display("FAIL reset_pulse: got %b want 0", pulse); end
        checks++;
        if (level !== '0) begin errors++; $display("FAIL reset_level: got %b want 0", level); end
        // Button already held while reset is released
        btn[4] = 1'b1;
        tick();
        rst_n = 1'b1;
        rel_edge = cyc + 1;
        pedge = -1;
        for (int n = 0; n < 15; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL reset_release cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            if (pulse[4] && pedge < 0) pedge = cyc;
        end
        checks++;
        if (pedge - rel_edge != LAT) begin
            errors++; $display("FAIL reset_release_latency: got %0d want %0d", pedge - rel_edge, LAT);
        end
        btn = '0;
        repeat (12) tick();
    endtask

    task automatic test_clean_press();
        int press_edge, pedge, npulse;
        logic lvl_before, lvl_at;
        btn[0] = 1'b1;
        press_edge = cyc + 1;
        pedge = -1; npulse = 0; lvl_before = 1'b0; lvl_at = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL clean_press cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            if (cyc == press_edge + LAT - 1) lvl_before = level[0];
            if (cyc == press_edge + LAT)     lvl_at = level[0];
            if (pulse[0]) begin npulse++; pedge = cyc; end
        end
        checks++;
        if (npulse != 1 || pedge - press_edge != LAT) begin
            errors++; $display("FAIL clean_press_timing: pulses %0d at +%0d want 1 at +%0d", npulse, pedge - press_edge, LAT);
        end
        checks++;
        if (lvl_before !== 1'b0 || lvl_at !== 1'b1) begin
            errors++; $display("FAIL clean_press_level: before %b at %b want 0 1", lvl_before, lvl_at);
        end
        btn[0] = 1'b0;
        npulse = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL clean_release cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            if (pulse[0]) npulse++;
        end
        checks++;
        if (npulse != 0 || level[0] !== 1'b0) begin
            errors++; $display("FAIL release_no_pulse: pulses %0d level %b want 0 0", npulse, level[0]);
        end
    endtask

    task automatic test_bounce();
        int last_edge, pedge, npulse;
        npulse = 0; pedge = -1; last_edge = 0;
        for (int k = 0; k < 10; k++) begin
            btn[2] = (k % 2 == 0);
            repeat (2) begin
                tick();
                checks++;
                if (pulse !== m_pulse || level !== m_level) begin
                    errors++;
                    $display("FAIL bounce cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
                end
                if (pulse[2]) npulse++;
            end
        end
        btn[2] = 1'b1;
        last_edge = cyc + 1;
        for (int n = 0; n < 15; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL bounce_hold cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            if (pulse[2]) begin npulse++; pedge = cyc; end
        end
        checks++;
        if (npulse != 1 || pedge - last_edge != LAT) begin
            errors++; $display("FAIL bounce_single: pulses %0d at +%0d want 1 at +%0d", npulse, pedge - last_edge, LAT);
        end
        btn[2] = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_pair();
        int n0, n1, n4;
        n0 = 0; n1 = 0; n4 = 0;
        btn[0] = 1'b1; btn[1] = 1'b1; btn[4] = 1'b1;
        for (int n = 0; n < 15; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL pair cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            n0 += int'(pulse[0]); n1 += int'(pulse[1]); n4 += int'(pulse[4]);
        end
        checks++;
        if (n0 != 0 || n1 != 0 || n4 != 1) begin
            errors++; $display("FAIL pair_counts: ch0 %0d ch1 %0d ch4 %0d want 0 0 1", n0, n1, n4);
        end
        btn = '0;
        repeat (12) tick();
    endtask

    task automatic test_inhibit();
        int np;
        np = 0;
        men = 1'b1;
        repeat (2) tick();
        btn[3] = 1'b1;
        for (int n = 0; n < 15; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL inhibit cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            np += int'(pulse[3]);
        end
        checks++;
        if (np != 0 || level[3] !== 1'b0) begin
            errors++; $display("FAIL inhibit_outputs: pulses %0d level %b want 0 0", np, level[3]);
        end
        men = 1'b0;
        tick();
        checks++;
        if (level[3] !== 1'b1 || pulse !== '0) begin
            errors++; $display("FAIL inhibit_resume: level %b pulse %b want 1 000000", level[3], pulse);
        end
        repeat (3) tick();
        btn[3] = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset_mid();
        int np;
        btn[5] = 1'b1;
        repeat (12) tick();
        checks++;
        if (level[5] !== 1'b1) begin errors++; $display("FAIL pre_reset_level: got %b want 1", level[5]); end
        btn[1] = 1'b1;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (pulse !== '0 || level !== '0) begin
            errors++; $display("FAIL async_reset: pulse %b level %b want 0 0", pulse, level);
        end
        btn = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        np = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            np += int'(pulse[1]);
        end
        checks++;
        if (np != 0) begin errors++; $display("FAIL aborted_press: pulses %0d want 0", np); end
    endtask

    task automatic test_long_hold();
        int press_edge, first;
        int got[$];
        int exp_off[$];
`ifdef CONTROL_BOTONES_AUTOREPEAT_EN
        exp_off = '{0, 20, 28, 36, 44, 52};
`else
        exp_off = '{0};
`endif
        btn[0] = 1'b1;
        press_edge = cyc + 1;
        for (int n = 0; n < 75; n++) begin
            if (n == 60) btn[0] = 1'b0;
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL long_hold cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
            if (pulse[0]) got.push_back(cyc);
        end
        checks++;
        if (got.size() != exp_off.size()) begin
            errors++; $display("FAIL long_hold_count: got %0d want %0d", got.size(), exp_off.size());
        end else begin
            first = got[0];
            checks++;
            if (first - press_edge != LAT) begin
                errors++; $display("FAIL long_hold_first: got +%0d want +%0d", first - press_edge, LAT);
            end
            for (int k = 0; k < got.size(); k++) begin
                checks++;
                if (got[k] - first != exp_off[k]) begin
                    errors++; $display("FAIL long_hold_offset %0d: got %0d want %0d", k, got[k] - first, exp_off[k]);
                end
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(9) == 0) btn[i] = ~btn[i];
            if ($urandom_range(59) == 0) men = ~men;
            tick();
            checks++;
            if (pulse !== m_pulse || level !== m_level) begin
                errors++;
                $display("FAIL random cyc %0d: pulse=%b level=%b want pulse=%b level=%b", cyc, pulse, level, m_pulse, m_level);
            end
        end
        btn = '0; men = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        rst_n = 1'b0; btn = '0; men = 1'b0;
        model_clear();
        test_reset();
        test_clean_press();
        test_bounce();
        test_pair();
        test_inhibit();
        test_reset_mid();
        test_long_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
